// File: rtl/ps2_pkg.sv
// PS/2 shared definitions: transmitter state encoding, keyboard command/response bytes, frame builder.
// Latency: none (declarations only).
// Backpressure: n/a.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE,
    DONE,
    ERR
  } tx_state_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RESP_ACK     = 8'hFA;
  localparam logic [7:0] RESP_RESEND  = 8'hFE;

  // Bits after the start bit, LSB first on the wire: {stop=1, odd parity, data}.
  function automatic logic [9:0] make_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-byte request/status bundle between a host controller and ps2_host_tx.
// Latency: none (wires only).
// Backpressure: tx_valid is held until tx_ready; the byte is taken on tx_valid && tx_ready.
//  master: drives tx_data, tx_valid; observes tx_ready, busy, done, error.
//  slave : the transmitter side of the same signals.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, error
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, error
  );
endinterface

// File: rtl/ps2_line_filter.sv
// Synchronises one raw PS/2 line and accepts a level change only after FILTER_LEN equal samples.
// Latency: 2 sync cycles + FILTER_LEN cycles from pin change to filtered level change.
// Backpressure: none; free-running every clk.
//  Ports: clk, nreset (async, active low), line_in (raw pin), level (filtered, resets to 1).
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic nreset,
  input  logic line_in,
  output logic level
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = line_in;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    cnt_d   = '0;
    // Any sample that agrees with the current level restarts the run count,
    // so a short glitch never reaches the filtered output.
    if (sync2_q != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = filt_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, shifts one command byte on device clocks.
// Latency: INHIBIT_CYC + device clocking (11 falling edges) + line-idle wait; done/error pulse one cycle.
// Backpressure: tx_ready only in IDLE; tx_valid is ignored while busy.
//  Ports: clk, nreset (async, active low); tx (ps2_host_tx_if.slave: tx_data/tx_valid/tx_ready/busy/done/error);
//         ps2_clk_in/ps2_dat_in raw pins; ps2_clk_oe/ps2_dat_oe open-drain pull-low enables.
//  Optional macro PS2_TX_RETRY_EN: re-send the same frame up to MAX_RETRY times before reporting error.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC  = 350,
  parameter int START_TO_CYC = 52500,
  parameter int XFER_TO_CYC  = 7000,
  parameter int FILTER_LEN   = 4
`ifdef PS2_TX_RETRY_EN
  ,
  parameter int MAX_RETRY    = 2
`endif
) (
  input  logic         clk,
  input  logic         nreset,
  ps2_host_tx_if.slave tx,
  input  logic         ps2_clk_in,
  input  logic         ps2_dat_in,
  output logic         ps2_clk_oe,
  output logic         ps2_dat_oe
);

  localparam int MAX_A   = (START_TO_CYC > XFER_TO_CYC) ? START_TO_CYC : XFER_TO_CYC;
  localparam int MAX_CYC = (MAX_A > INHIBIT_CYC) ? MAX_A : INHIBIT_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  tx_state_e        state_q, state_d;
  logic [9:0]       frame_q, frame_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic             clk_prev_q, clk_prev_d;

  logic             clk_lvl, dat_lvl;
  logic             clk_fell, xfer_exp, go_err;

`ifdef PS2_TX_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] retry_cnt_q, retry_cnt_d;
  logic          retry_ok;
  assign retry_ok = (retry_cnt_q < RW'(MAX_RETRY));
`endif

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk    (clk),
    .nreset (nreset),
    .line_in(ps2_clk_in),
    .level  (clk_lvl)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clk    (clk),
    .nreset (nreset),
    .line_in(ps2_dat_in),
    .level  (dat_lvl)
  );

  // The fall caused by our own inhibit lands inside INHIBIT (filter delay << INHIBIT_CYC)
  // and is ignored there, so REQ only sees device-generated edges.
  assign clk_fell = clk_prev_q & ~clk_lvl;
  assign xfer_exp = (cnt_q == CNT_W'(XFER_TO_CYC - 1));

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    bit_idx_d  = bit_idx_q;
    cnt_d      = cnt_q;
    clk_oe_d   = clk_oe_q;
    dat_oe_d   = dat_oe_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    clk_prev_d = clk_lvl;
    go_err     = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_cnt_d = retry_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (tx.tx_valid && ready_q) begin
          state_d  = INHIBIT;
          frame_d  = make_frame(tx.tx_data);
          cnt_d    = '0;
          clk_oe_d = 1'b1;
`ifdef PS2_TX_RETRY_EN
          retry_cnt_d = '0;
`endif
        end
      end

      INHIBIT: begin
        clk_oe_d = 1'b1;
        if (cnt_q == CNT_W'(INHIBIT_CYC - 1)) begin
          // Start bit goes down while the clock is still held; clock released next cycle.
          state_d  = REQ;
          dat_oe_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      REQ: begin
        clk_oe_d = 1'b0;
        if (clk_fell) begin
          state_d   = SHIFT;
          dat_oe_d  = ~frame_q[0];
          bit_idx_d = 4'd1;
          cnt_d     = '0;
        end else if (cnt_q == CNT_W'(START_TO_CYC - 1)) begin
          go_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      SHIFT: begin
        if (xfer_exp) begin
          go_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (clk_fell) begin
            dat_oe_d = ~frame_q[bit_idx_q];
            if (bit_idx_q == 4'd9) begin
              state_d = ACK;
            end else begin
              bit_idx_d = bit_idx_q + 4'd1;
            end
          end
        end
      end

      ACK: begin
        if (xfer_exp) begin
          go_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (clk_fell) begin
            if (!dat_lvl) begin
              state_d = WAIT_IDLE;
            end else begin
              go_err = 1'b1;
            end
          end
        end
      end

      WAIT_IDLE: begin
        if (xfer_exp) begin
          go_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (clk_lvl && dat_lvl) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      ERR: begin
        state_d = IDLE;
`ifdef PS2_TX_RETRY_EN
        if (retry_ok) begin
          retry_cnt_d = retry_cnt_q + 1'b1;
          state_d     = INHIBIT;
          clk_oe_d    = 1'b1;
          cnt_d       = '0;
        end
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (go_err) begin
      state_d  = ERR;
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
      error_d  = ~retry_ok;
`else
      error_d  = 1'b1;
`endif
    end

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      bit_idx_q  <= '0;
      cnt_q      <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      clk_prev_q <= 1'b1;
`ifdef PS2_TX_RETRY_EN
      retry_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      bit_idx_q  <= bit_idx_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      clk_prev_q <= clk_prev_d;
`ifdef PS2_TX_RETRY_EN
      retry_cnt_q <= retry_cnt_d;
`endif
    end
  end

  assign tx.tx_ready = ready_q;
  assign tx.busy     = busy_q;
  assign tx.done     = done_q;
  assign tx.error    = error_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_dat_oe  = dat_oe_q;

endmodule
